// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding,
// requester ids and the word-alignment mask.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  // Low byte-address bits that must be zero for a legal word access
  localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/dm_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the requester that did
// not win last time is granted.
module rr_pick2
  import dm_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_grant,
  output logic       o_any
);

  // One-hot grant selection
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_last == REQ_CPU) ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  assign o_any = |i_valid;

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares a single-port data memory between two valid/ready requesters with
// round-robin arbitration, one transaction in flight and a registered response.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [1:0]            i_req_valid,
  output logic [1:0]            o_req_ready,
  input  logic [1:0]            i_req_we,
  input  logic [2*ADDR_W-1:0]   i_req_addr,
  input  logic [63:0]           i_req_wdata,
  output logic [1:0]            o_resp_valid,
  output logic                  o_resp_err,
  output logic [31:0]           o_resp_rdata,
  output logic [ADDR_W-1:0]     o_dm_addr,
  output logic [31:0]           o_dm_wdata,
  output logic                  o_dm_we,
  input  logic [31:0]           i_dm_rdata
);

  localparam logic [ADDR_W-3:0] DEPTH_W = (ADDR_W-2)'(DEPTH);

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  logic                r_last;
  logic                r_id;
  logic                r_we;
  logic                r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;

  logic [1:0]          w_grant;
  logic                w_any;
  logic                w_sel_id;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [31:0]         w_sel_wdata;
  logic                w_sel_we;
  logic                w_sel_err;
  logic                w_accept;

  rr_pick2 u_pick (
    .i_valid (i_req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  assign w_sel_id    = w_grant[1];
  assign w_sel_addr  = w_sel_id ? i_req_addr[2*ADDR_W-1:ADDR_W] : i_req_addr[ADDR_W-1:0];
  assign w_sel_wdata = w_sel_id ? i_req_wdata[63:32] : i_req_wdata[31:0];
  assign w_sel_we    = w_sel_id ? i_req_we[1] : i_req_we[0];
  assign w_sel_err   = (|(w_sel_addr[1:0] & WORD_ALIGN_MASK[1:0])) ||
                       (w_sel_addr[ADDR_W-1:2] >= DEPTH_W);
  assign w_accept    = (r_state == ST_IDLE) && w_any && !i_reset;

  // Next-state and request-ready decode
  always_comb begin
    w_next_state = r_state;
    o_req_ready  = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          o_req_ready  = w_grant;
          w_next_state = ST_ACCESS;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCESS: w_next_state = ST_RESP;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request latches, grant history and captured read data
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
    end else if (w_accept) begin
      r_last  <= w_sel_id;
      r_id    <= w_sel_id;
      r_we    <= w_sel_we;
      r_err   <= w_sel_err;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
    end else if (r_state == ST_ACCESS) begin
      r_rdata <= (r_we || r_err) ? 32'h0 : i_dm_rdata;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  // Memory strobes in ACCESS only; response pulse in RESP, suppressed by reset
  always_comb begin
    o_dm_addr    = '0;
    o_dm_wdata   = 32'h0;
    o_dm_we      = 1'b0;
    o_resp_valid = 2'b00;
    o_resp_err   = 1'b0;
    case (r_state)
      ST_ACCESS: begin
        o_dm_addr  = r_addr;
        o_dm_wdata = r_wdata;
        o_dm_we    = r_we & ~r_err & ~i_reset;
      end
      ST_RESP: begin
        if (!i_reset) begin
          o_resp_valid = r_id ? 2'b10 : 2'b01;
          o_resp_err   = r_err;
        end else begin
          o_resp_valid = 2'b00;
          o_resp_err   = 1'b0;
        end
      end
      default: begin
        o_dm_we = 1'b0;
      end
    endcase
  end

  assign o_resp_rdata = r_rdata;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural data memory attached.
module tb_dm_port_arbiter;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_we = 2'b00;
  logic [63:0] req_addr = 64'h0;
  logic [63:0] req_wdata = 64'h0;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_rdata;

  logic [31:0] mem [0:DEPTH-1] = '{default: 32'h0};

  int n_vec = 0;
  int n_err = 0;

  logic        to, a_we, r_err;
  logic [31:0] a_addr, a_wdata, r_rdata;
  logic [1:0]  a_rv, r_rv;

  dm_port_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_err   (resp_err),
    .o_resp_rdata (resp_rdata),
    .o_dm_addr    (dm_addr),
    .o_dm_wdata   (dm_wdata),
    .o_dm_we      (dm_we),
    .i_dm_rdata   (dm_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dm_we) mem[dm_addr[11:2]] <= dm_wdata;
  assign dm_rdata = mem[dm_addr[11:2]];

  task automatic set_req(input int id, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    req_we[id]             = we;
    req_addr[id*32 +: 32]  = addr;
    req_wdata[id*32 +: 32] = wdata;
    req_valid[id]          = 1'b1;
  endtask

  // Drives one request from an IDLE negedge and samples the ACCESS and RESP cycles
  task automatic run_txn(input int id, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    to = 1'b1;
    a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0; a_rv = 2'b00;
    r_rv = 2'b00; r_err = 1'b0; r_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    set_req(id, we, addr, wdata);
    for (int k = 0; k < 10; k++) begin
      #1;
      if (req_ready[id]) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (to) begin
      req_valid[id] = 1'b0;
    end else begin
      @(negedge clk);
      req_valid[id] = 1'b0;
      a_we = dm_we; a_addr = dm_addr; a_wdata = dm_wdata; a_rv = resp_valid;
      @(negedge clk);
      r_rv = resp_valid; r_err = resp_err; r_rdata = resp_rdata;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 1'b0, 32'd4, 32'h0);
    set_req(1, 1'b0, 32'd8, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", req_ready); end
      n_vec++; if (resp_valid !== 2'b00 || resp_err !== 1'b0) begin n_err++; $display("FAIL reset_resp got %b/%b want 00/0", resp_valid, resp_err); end
      n_vec++; if (dm_we !== 1'b0 || dm_addr !== 32'h0 || dm_wdata !== 32'h0) begin n_err++; $display("FAIL reset_dm got we=%b addr=%h want 0/0", dm_we, dm_addr); end
      n_vec++; if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    end
    req_valid = 2'b00;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_txn(0, 1'b1, 32'd4, 32'd1);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL basic_st_accept got timeout want grant"); end
    n_vec++; if (a_we !== 1'b1 || a_addr !== 32'd4 || a_wdata !== 32'd1) begin n_err++; $display("FAIL basic_st_dm got we=%b addr=%h data=%h want 1/4/1", a_we, a_addr, a_wdata); end
    n_vec++; if (a_rv !== 2'b00) begin n_err++; $display("FAIL basic_st_early_resp got %b want 00", a_rv); end
    n_vec++; if (r_rv !== 2'b01 || r_err !== 1'b0 || r_rdata !== 32'h0) begin n_err++; $display("FAIL basic_st_resp got %b/%b/%h want 01/0/0", r_rv, r_err, r_rdata); end
    run_txn(0, 1'b0, 32'd4, 32'h0);
    n_vec++; if (a_we !== 1'b0 || a_addr !== 32'd4) begin n_err++; $display("FAIL basic_ld_dm got we=%b addr=%h want 0/4", a_we, a_addr); end
    n_vec++; if (r_rv !== 2'b01 || r_err !== 1'b0 || r_rdata !== 32'd1) begin n_err++; $display("FAIL basic_ld_resp got %b/%b/%h want 01/0/1", r_rv, r_err, r_rdata); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy, exp_rv;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    set_req(0, 1'b0, 32'd4, 32'h0);
    set_req(1, 1'b0, 32'd8, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_rdy = (i % 3 != 0) ? 2'b00 : ((i % 6 == 0) ? 2'b01 : 2'b10);
      exp_rv  = (i % 3 != 2) ? 2'b00 : ((i % 6 == 2) ? 2'b01 : 2'b10);
      n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready[%0d] got %b want %b", i, req_ready, exp_rdy); end
      n_vec++; if (resp_valid !== exp_rv) begin n_err++; $display("FAIL rr_resp[%0d] got %b want %b", i, resp_valid, exp_rv); end
      if (i % 3 == 2) begin
        n_vec++; if (resp_rdata !== ((i % 6 == 2) ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL rr_rdata[%0d] got %h", i, resp_rdata); end
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_errors();
    run_txn(1, 1'b1, 32'd6, 32'hFF);
    n_vec++; if (a_we !== 1'b0) begin n_err++; $display("FAIL misalign_st_we got %b want 0", a_we); end
    n_vec++; if (r_rv !== 2'b10 || r_err !== 1'b1 || r_rdata !== 32'h0) begin n_err++; $display("FAIL misalign_st_resp got %b/%b/%h want 10/1/0", r_rv, r_err, r_rdata); end
    n_vec++; if (mem[1] !== 32'd1) begin n_err++; $display("FAIL misalign_st_mem got %h want 1", mem[1]); end
    run_txn(0, 1'b0, 32'd4, 32'h0);
    run_txn(0, 1'b0, 32'd5, 32'h0);
    n_vec++; if (r_rv !== 2'b01 || r_err !== 1'b1 || r_rdata !== 32'h0) begin n_err++; $display("FAIL misalign_ld_resp got %b/%b/%h want 01/1/0", r_rv, r_err, r_rdata); end
    run_txn(0, 1'b0, 32'(4*DEPTH), 32'h0);
    n_vec++; if (r_rv !== 2'b01 || r_err !== 1'b1 || r_rdata !== 32'h0) begin n_err++; $display("FAIL range_ld_resp got %b/%b/%h want 01/1/0", r_rv, r_err, r_rdata); end
    run_txn(0, 1'b0, 32'd4, 32'h0);
    run_txn(0, 1'b0, 32'(4*DEPTH+4), 32'h0);
    n_vec++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin n_err++; $display("FAIL range_ld2_resp got %b/%h want 1/0", r_err, r_rdata); end
    run_txn(1, 1'b1, 32'(4*DEPTH-4), 32'h55);
    n_vec++; if (a_we !== 1'b1 || r_rv !== 2'b10 || r_err !== 1'b0) begin n_err++; $display("FAIL top_word_st got we=%b rv=%b err=%b want 1/10/0", a_we, r_rv, r_err); end
    n_vec++; if (mem[DEPTH-1] !== 32'h55 || mem[0] !== 32'h0 || mem[1] !== 32'd1) begin n_err++; $display("FAIL range_mem got %h/%h/%h want 55/0/1", mem[DEPTH-1], mem[0], mem[1]); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_req(0, 1'b1, 32'd8, 32'd2);
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rstmid_ready got %b want 01", req_ready); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++; if (dm_we !== 1'b0) begin n_err++; $display("FAIL rstmid_we got %b want 0", dm_we); end
    @(negedge clk);
    n_vec++; if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin n_err++; $display("FAIL rstmid_resp got rv=%b rdy=%b want 00/00", resp_valid, req_ready); end
    n_vec++; if (mem[2] !== 32'h0) begin n_err++; $display("FAIL rstmid_mem got %h want 0", mem[2]); end
    req_valid = 2'b00;
    reset = 1'b0;
    run_txn(0, 1'b0, 32'd8, 32'h0);
    n_vec++; if (to !== 1'b0 || r_rv !== 2'b01 || r_rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_ld got to=%b rv=%b data=%h want 0/01/0", to, r_rv, r_rdata); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_req(0, 1'b0, 32'd4, 32'h0);
    for (int i = 0; i < 9; i++) begin
      #1;
      n_vec++; if (req_ready !== ((i % 3 == 0) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL b2b_ready[%0d] got %b", i, req_ready); end
      n_vec++; if (resp_valid !== ((i % 3 == 2) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL b2b_resp[%0d] got %b", i, resp_valid); end
      if (i % 3 == 2) begin
        n_vec++; if (resp_rdata !== 32'd1) begin n_err++; $display("FAIL b2b_rdata[%0d] got %h want 1", i, resp_rdata); end
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
